pe_mac_pipe: RTL and testbench
==============================

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand width (IEEE-754 single).
REQ-002 Parameter ACC_WIDTH, 32, accumulator/result width (IEEE-754 single).
REQ-003 Parameter MAX_K, 256, max terms per frame; CNT_W = clog2(MAX_K+1).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 clr_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-008 start  in  1  first term of frame; qualified by accepted beat.
REQ-009 last  in  1  final term of frame; qualified by accepted beat.
REQ-010 a, b  in  DATA_WIDTH each  FP operands.
REQ-011 out_valid  out  1  result held valid.
REQ-012 out_ready  in  1  consumer accepts result when out_valid && out_ready.
REQ-013 out_c  out  ACC_WIDTH  frame dot-product result.
REQ-014 out_ovf  out  1  sticky overflow for the frame.
REQ-015 out_count  out  CNT_W  terms accumulated in the frame, saturating at MAX_K.

Function
REQ-016 Advance enable adv = !(out_valid && !out_ready); in_ready SHALL equal adv.
REQ-017 Stage 1 (S1) SHALL register product a*b, start, last, multiplier overflow and valid when adv; S1 holds when !adv.
REQ-018 Stage 2 SHALL update accumulator only when adv && S1 valid: start -> acc = product, cnt = 1, ovf = mul_ovf; else acc = acc + product, cnt = min(cnt+1, MAX_K), ovf |= mul_ovf | add_ovf.
REQ-019 When S1 valid && last && adv, the updated acc/ovf/cnt values SHALL load out_c/out_ovf/out_count and set out_valid next cycle.
REQ-020 Latency: last beat accepted at edge N -> out_valid high after edge N+2 with no backpressure.
REQ-021 out_valid SHALL clear after a handshake unless a new last loads in the same cycle (back-to-back results allowed).
REQ-022 out_c/out_ovf/out_count SHALL stay stable while out_valid && !out_ready.
REQ-023 start && last on one beat SHALL yield a single-term frame: out_c = product, out_count = 1.
REQ-024 A beat without start following a completed frame SHALL accumulate onto the retained acc (no implicit clear).
REQ-025 Throughput: one beat per cycle while out_ready stays high.
REQ-026 Idle cycles (no valid beat) inside a frame SHALL leave acc, cnt, ovf unchanged.

Reset
REQ-027 clr_n low at an edge SHALL clear S1 valid, acc = 0, cnt = 0, ovf = 0, out_valid = 0, out_c = 0, out_ovf = 0, out_count = 0; in_ready = 1 after reset.
REQ-028 Reset mid-frame SHALL discard the partial frame; no out_valid for it.

Structure
REQ-029 Shared package pe_pkg SHALL hold FP_ZERO, FP_ONE constants and default DATA_WIDTH/ACC_WIDTH.
REQ-030 FP arithmetic SHALL reuse the existing multiplier_32bit and adder_32bit combinational cores.
REQ-031 Output hold register with handshake SHALL be sub-module pe_out_buf.

Verification
REQ-032 Frame (0x3F800000*0x40000000, start) then (0x40400000*0x40800000, last), out_ready = 1 -> out_c = 0x41600000 (14.0), out_count = 2, out_ovf = 0, out_valid 2 cycles after last.
REQ-033 Single beat start && last, 0x40000000*0x40400000 -> out_c = 0x40C00000, out_count = 1.
REQ-034 out_ready = 0 with two back-to-back single-beat frames -> in_ready drops, first result held stable, second delivered after release; no loss.
REQ-035 0x7F000000*0x7F000000 mid-frame -> out_ovf = 1 at frame end; next frame with start and normal operands -> out_ovf = 0.
REQ-036 clr_n low for 1 cycle after 3 beats of a 5-beat frame -> no output; fresh frame 1.0*1.0 (start, last) -> out_c = 0x3F800000.
REQ-037 MAX_K = 4, 6-beat frame of 1.0*1.0 -> out_count = 4, out_c = 0x40C00000.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants, result type and rounding helper for the PE MAC datapath.
// The FP cores produce a normalised 27-bit significand; fp_round_pack finishes them.
package pe_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ACC_WIDTH  = 32;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } fp_res_t;

  // norm: [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
  // Round-to-nearest-even; exponent overflow saturates to inf, underflow flushes to zero.
  function automatic fp_res_t fp_round_pack(input logic              sign,
                                            input logic signed [9:0] e_in,
                                            input logic [26:0]       norm);
    logic [24:0]       m;
    logic [22:0]       frac;
    logic              up;
    logic signed [9:0] e;
    fp_res_t           r;
    up   = norm[2] & (norm[3] | norm[1] | norm[0]);
    m    = {1'b0, norm[26:3]} + {24'd0, up};
    e    = m[24] ? e_in + 10'sd1 : e_in;
    frac = m[24] ? m[23:1] : m[22:0];
    if (e >= 10'sd255) begin
      r = '{ovf: 1'b1, val: {sign, FP_EXP_MAX, 23'd0}};
    end else if (e <= 10'sd0) begin
      r = '{ovf: 1'b0, val: {sign, 31'd0}};
    end else begin
      r = '{ovf: 1'b0, val: {sign, e[7:0], frac}};
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormals flush to zero; o_ovf flags an inf/NaN result.
module adder_32bit
  import pe_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum,
  output logic        o_ovf
);

  logic              w_swap;
  logic [31:0]       w_big;
  logic [31:0]       w_sml;
  logic [23:0]       w_big_m;
  logic [23:0]       w_sml_m;
  logic [7:0]        w_diff;
  logic [26:0]       w_sml_ext;
  logic [26:0]       w_mask;
  logic [26:0]       w_aligned;
  logic              w_eff_sub;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic [26:0]       w_norm;
  logic signed [9:0] w_exp;
  fp_res_t           w_res;

  always_comb begin
    // Order by magnitude so the alignment shift is always applied to the smaller operand.
    w_swap    = i_b[30:0] > i_a[30:0];
    w_big     = w_swap ? i_b : i_a;
    w_sml     = w_swap ? i_a : i_b;
    w_big_m   = (w_big[30:23] == 8'd0) ? 24'd0 : {1'b1, w_big[22:0]};
    w_sml_m   = (w_sml[30:23] == 8'd0) ? 24'd0 : {1'b1, w_sml[22:0]};
    w_diff    = w_big[30:23] - w_sml[30:23];
    w_sml_ext = {w_sml_m, 3'b000};
    w_mask    = ~({27{1'b1}} << w_diff);
    if (w_diff >= 8'd27) begin
      w_aligned = {26'd0, |w_sml_m};
    end else begin
      w_aligned = (w_sml_ext >> w_diff) | {26'd0, |(w_sml_ext & w_mask)};
    end
    w_eff_sub = w_big[31] ^ w_sml[31];
    w_sum     = w_eff_sub ? {1'b0, w_big_m, 3'b000} - {1'b0, w_aligned}
                          : {1'b0, w_big_m, 3'b000} + {1'b0, w_aligned};
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end
    w_exp = $signed({2'b00, w_big[30:23]});
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], |w_sum[1:0]};
      w_exp  = w_exp + 10'sd1;
    end else begin
      w_norm = w_sum[26:0] << w_lz;
      w_exp  = w_exp - $signed({5'd0, w_lz});
    end
    w_res = fp_round_pack(w_big[31], w_exp, w_norm);
    o_sum = w_res.val;
    o_ovf = w_res.ovf;
    if (w_big[30:23] == FP_EXP_MAX) begin
      o_ovf = 1'b1;
      o_sum = (w_big[22:0] != 23'd0 || (w_sml[30:23] == FP_EXP_MAX && w_eff_sub)) ?
              FP_QNAN : {w_big[31], FP_EXP_MAX, 23'd0};
    end else if (w_sum == 28'd0) begin
      o_ovf = 1'b0;
      o_sum = FP_ZERO;
    end
  end

endmodule

// File: rtl/multiplier_32bit.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Denormal inputs are treated as zero; o_ovf flags an inf/NaN result.
module multiplier_32bit
  import pe_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p,
  output logic        o_ovf
);

  logic              w_sign;
  logic [7:0]        w_ea;
  logic [7:0]        w_eb;
  logic [47:0]       w_prod;
  logic [26:0]       w_norm;
  logic signed [9:0] w_exp;
  logic              w_nan;
  fp_res_t           w_res;

  assign w_sign = i_a[31] ^ i_b[31];
  assign w_ea   = i_a[30:23];
  assign w_eb   = i_b[30:23];
  assign w_prod = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
  assign w_nan  = (w_ea == FP_EXP_MAX && i_a[22:0] != 23'd0) ||
                  (w_eb == FP_EXP_MAX && i_b[22:0] != 23'd0) ||
                  (w_ea == 8'd0) || (w_eb == 8'd0);

  always_comb begin
    w_exp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
    if (w_prod[47]) begin
      w_norm = {w_prod[47:22], |w_prod[21:0]};
      w_exp  = w_exp + 10'sd1;
    end else begin
      w_norm = {w_prod[46:21], |w_prod[20:0]};
    end
    w_res = fp_round_pack(w_sign, w_exp, w_norm);
    o_p   = w_res.val;
    o_ovf = w_res.ovf;
    if (w_ea == FP_EXP_MAX || w_eb == FP_EXP_MAX) begin
      // w_nan here also covers inf * 0
      o_ovf = 1'b1;
      o_p   = w_nan ? FP_QNAN : {w_sign, FP_EXP_MAX, 23'd0};
    end else if (w_ea == 8'd0 || w_eb == 8'd0) begin
      o_ovf = 1'b0;
      o_p   = {w_sign, 31'd0};
    end
  end

endmodule

// File: rtl/pe_out_buf.sv
// Result holding register with valid/ready handshake; a load may coincide with
// the handshake of the previous result so results can stream back-to-back.
module pe_out_buf #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                 i_clk,
  input  logic                 i_clr_n,
  input  logic                 i_load,
  input  logic [ACC_WIDTH-1:0] i_c,
  input  logic                 i_ovf,
  input  logic [CNT_W-1:0]     i_count,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [ACC_WIDTH-1:0] o_c,
  output logic                 o_ovf,
  output logic [CNT_W-1:0]     o_count
);

  logic                 r_valid;
  logic [ACC_WIDTH-1:0] r_c;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_count;

  // The producer only asserts i_load when the buffer is empty or draining this cycle.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_valid <= 1'b0;
      r_c     <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_c     <= i_c;
      r_ovf   <= i_ovf;
      r_count <= i_count;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_c     = r_c;
  assign o_ovf   = r_ovf;
  assign o_count = r_count;

endmodule

// File: rtl/pe_mac_pipe.sv
// Pipelined FP32 dot-product PE: S1 registers a*b, S2 accumulates, pe_out_buf holds the result.
// Last beat accepted at edge N reaches out_valid after edge N+2; the whole pipe stalls on backpressure.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter  int unsigned MAX_K      = 256,
  localparam int unsigned CNT_W      = $clog2(MAX_K + 1)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_c,
  output logic                  out_ovf,
  output logic [CNT_W-1:0]      out_count
);

  logic                 w_adv;
  logic [ACC_WIDTH-1:0] w_prod;
  logic                 w_mul_ovf;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_ovf;

  logic                 r_s1_valid;
  logic                 r_s1_start;
  logic                 r_s1_last;
  logic                 r_s1_ovf;
  logic [ACC_WIDTH-1:0] r_s1_prod;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic                 r_s2_last;

  logic [ACC_WIDTH-1:0] w_acc_d;
  logic [CNT_W-1:0]     w_cnt_d;
  logic                 w_ovf_d;

  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  // Both cores are single precision; DATA_WIDTH and ACC_WIDTH must stay 32.
  multiplier_32bit u_mul (
    .i_a   (a),
    .i_b   (b),
    .o_p   (w_prod),
    .o_ovf (w_mul_ovf)
  );

  adder_32bit u_add (
    .i_a   (r_acc),
    .i_b   (r_s1_prod),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_s1_valid <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_prod  <= FP_ZERO;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_start <= start;
        r_s1_last  <= last;
        r_s1_ovf   <= w_mul_ovf;
        r_s1_prod  <= w_prod;
      end
    end
  end

  // Without a start the accumulator carries on from its retained value, even across frames.
  always_comb begin
    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    w_ovf_d = r_ovf;
    if (r_s1_valid) begin
      if (r_s1_start) begin
        w_acc_d = r_s1_prod;
        w_cnt_d = CNT_W'(1);
        w_ovf_d = r_s1_ovf;
      end else begin
        w_acc_d = w_sum;
        w_cnt_d = (r_cnt >= CNT_W'(MAX_K)) ? r_cnt : r_cnt + CNT_W'(1);
        w_ovf_d = r_ovf | r_s1_ovf | w_add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_acc     <= FP_ZERO;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_s2_last <= 1'b0;
    end else if (w_adv) begin
      r_acc     <= w_acc_d;
      r_cnt     <= w_cnt_d;
      r_ovf     <= w_ovf_d;
      r_s2_last <= r_s1_valid && r_s1_last;
    end
  end

  pe_out_buf #(
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_W     (CNT_W)
  ) u_out_buf (
    .i_clk   (clk),
    .i_clr_n (clr_n),
    .i_load  (w_adv && r_s2_last),
    .i_c     (r_acc),
    .i_ovf   (r_ovf),
    .i_count (r_cnt),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_c     (out_c),
    .o_ovf   (out_ovf),
    .o_count (out_count)
  );

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: stimulus pushes hand-computed frame results,
// monitors pop and compare on each output handshake.
module tb_pe_mac_pipe;

  localparam int unsigned CW  = $clog2(256 + 1);
  localparam int unsigned CW4 = $clog2(4 + 1);

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FOUR  = 32'h4080_0000;
  localparam logic [31:0] SIX   = 32'h40C0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr_n, in_valid, in_valid4, start, last, out_ready;
  logic [31:0]   a, b;
  logic          in_ready, out_valid, out_ovf;
  logic [31:0]   out_c;
  logic [CW-1:0] out_count;
  logic          in_ready4, out_valid4, out_ovf4;
  logic [31:0]   out_c4;
  logic [CW4-1:0] out_count4;

  typedef struct packed {
    logic [31:0] c;
    logic        ovf;
    logic [8:0]  cnt;
  } res_t;

  res_t q[$];
  res_t q4[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  pe_mac_pipe u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .last      (last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  pe_mac_pipe #(.MAX_K(4)) u_dut4 (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .start     (start),
    .last      (last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_c     (out_c4),
    .out_ovf   (out_ovf4),
    .out_count (out_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic ovf, input int unsigned cnt,
                      input bit to4);
    res_t r;
    r.c   = c;
    r.ovf = ovf;
    r.cnt = 9'(cnt);
    if (to4) q4.push_back(r);
    else q.push_back(r);
  endtask

  // Called near a falling edge; returns at the falling edge after the beat is accepted.
  task automatic beat(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                      input logic l, input bit to4);
    int t;
    bit ok;
    a = ia;
    b = ib;
    start = s;
    last = l;
    if (to4) in_valid4 = 1'b1;
    else in_valid = 1'b1;
    t = 0;
    do begin
      #1;
      ok = to4 ? in_ready4 : in_ready;
      @(negedge clk);
      t++;
    end while (!ok && t < 40);
    check("beat_accept", 64'(ok), 64'(1));
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : mon
    res_t exp_r;
    res_t held;
    bit   hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_stable", 64'({out_c, out_ovf, 9'(out_count)}), 64'(held));
      end
      hold = out_valid && !out_ready;
      held = {out_c, out_ovf, 9'(out_count)};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'(out_c), 64'hDEAD_0000_0000);
        end else begin
          exp_r = q.pop_front();
          check("result_c", 64'(out_c), 64'(exp_r.c));
          check("result_ovf", 64'(out_ovf), 64'(exp_r.ovf));
          check("result_count", 64'(out_count), 64'(exp_r.cnt));
        end
      end
    end
  end

  initial begin : mon4
    res_t exp_r;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) begin
          check("unexpected_result4", 64'(out_c4), 64'hDEAD_0000_0000);
        end else begin
          exp_r = q4.pop_front();
          check("result4_c", 64'(out_c4), 64'(exp_r.c));
          check("result4_ovf", 64'(out_ovf4), 64'(exp_r.ovf));
          check("result4_count", 64'(out_count4), 64'(exp_r.cnt));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    int c0;
    clr_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; start = 1'b0; last = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;
    idle(3);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_c", 64'(out_c), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    clr_n = 1'b1;
    idle(1);

    // 1*2 + 3*4 = 14, with latency probe
    push(32'h4160_0000, 1'b0, 2, 1'b0);
    beat(ONE, TWO, 1'b1, 1'b0, 1'b0);
    beat(THREE, FOUR, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    check("latency_n1", 64'(out_valid), 64'(0));
    @(negedge clk); #1;
    check("latency_n2", 64'(out_valid), 64'(1));
    idle(3);

    // single-term frame 2*3 = 6
    push(SIX, 1'b0, 1, 1'b0);
    beat(TWO, THREE, 1'b1, 1'b1, 1'b0);
    idle(4);

    // no implicit clear: 1*2 = 2, then beat without start 1*1 -> 3
    push(TWO, 1'b0, 1, 1'b0);
    beat(ONE, TWO, 1'b1, 1'b1, 1'b0);
    push(THREE, 1'b0, 2, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b1, 1'b0);
    idle(4);

    // idle cycles inside a frame
    push(TWO, 1'b0, 2, 1'b0);
    beat(ONE, ONE, 1'b1, 1'b0, 1'b0);
    idle(3);
    beat(ONE, ONE, 1'b0, 1'b1, 1'b0);
    idle(4);

    // exact cancellation 6 + (-6) = +0
    push(32'h0000_0000, 1'b0, 2, 1'b0);
    beat(TWO, THREE, 1'b1, 1'b0, 1'b0);
    beat(32'hC000_0000, THREE, 1'b0, 1'b1, 1'b0);
    idle(4);

    // 1.5*1.5 + 0.5*0.5 = 2.5
    push(32'h4020_0000, 1'b0, 2, 1'b0);
    beat(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b0, 1'b0);
    beat(32'h3F00_0000, 32'h3F00_0000, 1'b0, 1'b1, 1'b0);
    idle(4);

    // four beats in four cycles
    push(FOUR, 1'b0, 4, 1'b0);
    c0 = cyc;
    beat(ONE, ONE, 1'b1, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b1, 1'b0);
    check("throughput_cycles", 64'(cyc - c0), 64'(4));
    idle(4);

    // backpressure with two single-beat frames
    out_ready = 1'b0;
    push(SIX, 1'b0, 1, 1'b0);
    beat(TWO, THREE, 1'b1, 1'b1, 1'b0);
    push(FOUR, 1'b0, 1, 1'b0);
    beat(TWO, TWO, 1'b1, 1'b1, 1'b0);
    idle(4);
    #1;
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_out_c", 64'(out_c), 64'(SIX));
    @(negedge clk);
    out_ready = 1'b1;
    idle(5);

    // overflow is sticky within the frame and cleared by the next start
    push(32'h7F80_0000, 1'b1, 3, 1'b0);
    beat(ONE, ONE, 1'b1, 1'b0, 1'b0);
    beat(32'h7F00_0000, 32'h7F00_0000, 1'b0, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b1, 1'b0);
    push(SIX, 1'b0, 1, 1'b0);
    beat(TWO, THREE, 1'b1, 1'b1, 1'b0);
    idle(4);

    // reset after 3 of 5 beats discards the partial frame
    beat(ONE, ONE, 1'b1, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b0, 1'b0);
    beat(ONE, ONE, 1'b0, 1'b0, 1'b0);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    idle(4);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_count", 64'(out_count), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    push(ONE, 1'b0, 1, 1'b0);
    beat(ONE, ONE, 1'b1, 1'b1, 1'b0);
    idle(4);

    // MAX_K = 4: six terms saturate the count but not the sum
    push(SIX, 1'b0, 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      beat(ONE, ONE, (i == 0), (i == 5), 1'b1);
    end
    idle(5);

    check("queue_drained", 64'(q.size()), 64'(0));
    check("queue4_drained", 64'(q4.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
